// File: rtl/mesh_pkg.sv
// Shared definitions for the MAC mesh and its result-side drain:
// default geometry, drain FSM states and the flat-bus lane slicing helper.
package mesh_pkg;

    localparam int OUT_BIT_D = 20;
    localparam int RES_BIT_D = 8;
    localparam int MESH_X_D  = 4;
    localparam int MESH_Y_D  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

    // Low bit of lane 'lane' on a flat bus packed lane 0 at the LSBs.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mesh_requant.sv
// Requantizes one signed accumulator value: arithmetic right shift with
// round-half-up, then signed saturation to RES_BIT.
module mesh_requant #(
    parameter int OUT_BIT = 20,
    parameter int RES_BIT = 8,
    parameter int SH_W    = 5
) (
    input  logic signed [OUT_BIT-1:0] i_x,
    input  logic        [SH_W-1:0]    i_shift,
    output logic signed [RES_BIT-1:0] o_y
);

    // One guard bit so that adding the rounding bias can never wrap.
    localparam logic signed [OUT_BIT:0] SAT_MAX = (OUT_BIT+1)'((2 ** (RES_BIT-1)) - 1);
    localparam logic signed [OUT_BIT:0] SAT_MIN = (OUT_BIT+1)'(-(2 ** (RES_BIT-1)));

    logic signed [OUT_BIT:0] w_ext;
    logic signed [OUT_BIT:0] w_bias;
    logic signed [OUT_BIT:0] w_sum;
    logic signed [OUT_BIT:0] w_shr;

    // Round, shift and clamp the selected lane.
    always_comb begin
        w_ext = {i_x[OUT_BIT-1], i_x};
        if (i_shift == SH_W'(0)) begin
            w_bias = (OUT_BIT+1)'(0);
        end else begin
            w_bias = (OUT_BIT+1)'(1) << (i_shift - SH_W'(1));
        end
        w_sum = w_ext + w_bias;
        w_shr = w_sum >>> i_shift;
        if (w_shr > SAT_MAX) begin
            o_y = SAT_MAX[RES_BIT-1:0];
        end else if (w_shr < SAT_MIN) begin
            o_y = SAT_MIN[RES_BIT-1:0];
        end else begin
            o_y = w_shr[RES_BIT-1:0];
        end
    end

endmodule

// File: rtl/mesh_drain.sv
// Snapshots every mesh accumulator on a capture strobe and streams the
// requantized lanes out one per cycle over a valid/ready handshake.
module mesh_drain
    import mesh_pkg::*;
#(
    parameter int OUT_BIT = OUT_BIT_D,
    parameter int RES_BIT = RES_BIT_D,
    parameter int MESH_X  = MESH_X_D,
    parameter int MESH_Y  = MESH_Y_D,
    localparam int N      = MESH_X * MESH_Y,
    localparam int SH_W   = $clog2(OUT_BIT),
    localparam int IDX_W  = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic [N*OUT_BIT-1:0]   acc_in,
    input  logic [SH_W-1:0]        shift,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [RES_BIT-1:0]     m_data,
    output logic [IDX_W-1:0]       m_idx,
    output logic                   m_last,
    output logic                   busy,
    output logic                   overrun
);

    drain_state_e              r_state;
    drain_state_e              w_state_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [OUT_BIT-1:0]        r_snap [N];
    logic [SH_W-1:0]           r_shift;
    logic                      r_overrun;
    logic                      w_overrun_nxt;
    logic                      w_load;
    logic                      w_send;
    logic                      w_hs;
    logic                      w_last_lane;
    logic signed [RES_BIT-1:0] w_req;

    assign w_send      = (r_state == SEND);
    assign w_hs        = w_send & m_ready;
    assign w_last_lane = (r_idx == IDX_W'(N - 1));

    // Next-state, lane index and overrun decision.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_load        = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (capture) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = IDX_W'(0);
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (w_hs && w_last_lane) begin
                    // A capture landing on the final handshake chains straight on.
                    w_idx_nxt = IDX_W'(0);
                    if (capture) begin
                        w_load      = 1'b1;
                        w_state_nxt = SEND;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end else begin
                        w_idx_nxt = r_idx;
                    end
                    w_overrun_nxt = capture;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = IDX_W'(0);
            end
        endcase
    end

    // State, index, snapshot and overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= IDX_W'(0);
            r_shift   <= SH_W'(0);
            r_overrun <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_snap[i] <= OUT_BIT'(0);
            end
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_overrun <= w_overrun_nxt;
            if (w_load) begin
                r_shift <= shift;
                for (int i = 0; i < N; i++) begin
                    r_snap[i] <= acc_in[lane_lo(i, OUT_BIT) +: OUT_BIT];
                end
            end
        end
    end

    mesh_requant #(
        .OUT_BIT (OUT_BIT),
        .RES_BIT (RES_BIT),
        .SH_W    (SH_W)
    ) u_requant (
        .i_x     (r_snap[r_idx]),
        .i_shift (r_shift),
        .o_y     (w_req)
    );

    assign m_valid = w_send;
    assign busy    = w_send;
    assign overrun = r_overrun;
    assign m_data  = w_send ? w_req : RES_BIT'(0);
    assign m_idx   = w_send ? r_idx : IDX_W'(0);
    assign m_last  = w_send & w_last_lane;

endmodule

// File: tb/tb_mesh_drain.sv
// Directed bench for mesh_drain: stimulus pushes expected words into a
// scoreboard queue, a negedge monitor pops and compares on each handshake.
module tb_mesh_drain;

    localparam int OB = 20;
    localparam int N  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            capture;
    logic [N*OB-1:0] acc_in;
    logic [4:0]      shift;
    logic            m_valid;
    logic            m_ready;
    logic [7:0]      m_data;
    logic [3:0]      m_idx;
    logic            m_last;
    logic            busy;
    logic            overrun;

    mesh_drain dut (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .acc_in  (acc_in),
        .shift   (shift),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_idx   (m_idx),
        .m_last  (m_last),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] i;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    bit   mon_en = 1'b0;

    int v2[16] = '{40, 24, -24, -40, 2047, -2048, 8, -8, 0, 7, -9, 100000, -100000, 2031, -2056, -2057};
    int e2[16] = '{3, 2, -1, -2, 127, -128, 1, 0, 0, 0, -1, 127, -128, 127, -128, -128};
    int v3[6]  = '{262144, 262143, -262144, -262145, -524288, 524287};
    int e3[6]  = '{1, 0, 0, -1, -1, 1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int lane, input int val);
        exp_t e;
        e.d = 8'(val);
        e.i = 4'(lane);
        e.l = (lane == N - 1);
        sb.push_back(e);
    endtask

    task automatic set_lane(input int lane, input int val);
        acc_in[lane*OB +: OB] = 20'(val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int target);
        for (int k = 0; k < 64; k++) begin
            if (m_valid === 1'b1 && m_idx === 4'(target)) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL wait_idx: timeout waiting for idx %0d, got %0h", target, m_idx);
    endtask

    task automatic drain(input bit rnd, output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0 && m_valid !== 1'b1) return;
            if (busy === 1'b1) busy_cycles++;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        total++;
        bad++;
        $display("FAIL drain: timeout, %0d words still expected", sb.size());
    endtask

    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic [3:0] prev_i;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (m_valid === 1'b1) begin
                if (prev_stall) begin
                    chk("stall_data", 32'(m_data), 32'(prev_d));
                    chk("stall_idx", 32'(m_idx), 32'(prev_i));
                end
                if (m_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got idx %0d data %0h expected none", m_idx, m_data);
                    end else begin
                        e = sb.pop_front();
                        chk("data", 32'(m_data), 32'(e.d));
                        chk("idx", 32'(m_idx), 32'(e.i));
                        chk("last", 32'(m_last), 32'(e.l));
                    end
                end
                prev_stall = (m_ready !== 1'b1);
                prev_d     = m_data;
                prev_i     = m_idx;
            end else begin
                chk("idle_data", 32'(m_data), 32'd0);
                chk("idle_idx", 32'(m_idx), 32'd0);
                chk("idle_last", 32'(m_last), 32'd0);
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int bc;
        rst = 1'b1; capture = 1'b0; m_ready = 1'b0; acc_in = '0; shift = 5'd0;
        tick();
        tick();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_idx", 32'(m_idx), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        mon_en = 1'b1;
        rst = 1'b0;
        tick();

        // Identity lanes, no shift, full-rate drain.
        for (int i = 0; i < N; i++) begin set_lane(i, i); push(i, i); end
        shift = 5'd0; m_ready = 1'b1; capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("first_valid", 32'(m_valid), 32'd1);
        chk("first_idx", 32'(m_idx), 32'd0);
        drain(1'b0, bc);
        chk("busy_cycles", 32'(bc), 32'd16);

        // Rounding and saturation at shift 4 under random backpressure.
        for (int i = 0; i < N; i++) begin set_lane(i, v2[i]); push(i, e2[i]); end
        shift = 5'd4; capture = 1'b1;
        tick();
        capture = 1'b0;
        drain(1'b1, bc);
        m_ready = 1'b1;
        tick();

        // Capture while streaming is dropped and flagged.
        for (int i = 0; i < N; i++) begin set_lane(i, 3 * i); push(i, 3 * i); end
        shift = 5'd0; capture = 1'b1;
        tick();
        capture = 1'b0;
        wait_idx(5);
        for (int i = 0; i < N; i++) set_lane(i, -77);
        shift = 5'd3; capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("overrun_pulse", 32'(overrun), 32'd1);
        chk("overrun_idx", 32'(m_idx), 32'd6);
        tick();
        chk("overrun_clear", 32'(overrun), 32'd0);
        drain(1'b0, bc);

        // Capture coinciding with the final handshake chains with no bubble.
        for (int i = 0; i < N; i++) begin set_lane(i, 100 + i); push(i, 100 + i); end
        shift = 5'd0; capture = 1'b1;
        tick();
        capture = 1'b0;
        wait_idx(15);
        for (int i = 0; i < N; i++) begin set_lane(i, v3[i % 6]); push(i, e3[i % 6]); end
        shift = 5'd19; capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("chain_valid", 32'(m_valid), 32'd1);
        chk("chain_idx", 32'(m_idx), 32'd0);
        chk("chain_busy", 32'(busy), 32'd1);
        chk("chain_overrun", 32'(overrun), 32'd0);
        drain(1'b0, bc);
        chk("chain_busy_cycles", 32'(bc), 32'd16);

        // Reset in the middle of a stream discards the snapshot.
        for (int i = 0; i < N; i++) set_lane(i, 50 + i);
        for (int i = 0; i < 7; i++) push(i, 50 + i);
        shift = 5'd0; capture = 1'b1;
        tick();
        capture = 1'b0;
        wait_idx(7);
        m_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_idx", 32'(m_idx), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_sb", 32'(sb.size()), 32'd0);
        for (int i = 0; i < N; i++) begin set_lane(i, 15 - i); push(i, 15 - i); end
        m_ready = 1'b1; capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("restart_idx", 32'(m_idx), 32'd0);
        chk("restart_valid", 32'(m_valid), 32'd1);
        drain(1'b0, bc);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
